// File: rtl/si5340_cfg_seq.sv
// Si5340 register-load sequencer: walks a {page, reg, data} ROM and issues write-only
// I2C byte commands, inserting page-select writes on page change and a settle delay after the preamble.
module si5340_cfg_seq #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter logic [6:0]  DEV_ADDR     = 7'h74,
    parameter int unsigned ROM_DEPTH    = 512,
    parameter int unsigned PREAMBLE_LEN = 3,
    parameter int unsigned DELAY_CYCLES = 30_000_000,
    parameter int unsigned TIMEOUT      = 100_000
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         error_o,
    output logic [$clog2(ROM_DEPTH)-1:0] rom_addr_o,
    input  logic [23:0]                  rom_data_i,
    output logic                         start_o,
    output logic                         stop_o,
    output logic                         read_o,
    output logic                         write_o,
    output logic                         ack_in_o,
    output logic [DATA_WIDTH-1:0]        din_o,
    input  logic [DATA_WIDTH-1:0]        dout_i,
    input  logic                         cmd_ack_i
);
    localparam int unsigned AW    = $clog2(ROM_DEPTH);
    localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned DLY_W = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;

    localparam logic [AW-1:0]    LAST_ADDR = AW'(ROM_DEPTH - 32'd1);
    localparam logic [AW-1:0]    PRE_ADDR  = AW'((PREAMBLE_LEN == 0) ? 32'd0 : PREAMBLE_LEN - 32'd1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'((TIMEOUT == 0) ? 32'd0 : TIMEOUT - 32'd1);
    localparam logic [DLY_W-1:0] DLY_LAST  = DLY_W'((DELAY_CYCLES == 0) ? 32'd0 : DELAY_CYCLES - 32'd1);
    localparam logic [7:0]       ADDR_BYTE = {DEV_ADDR, 1'b0};
    localparam logic [7:0]       PAGE_REG  = 8'h01;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_LATCH, S_PG_DEV, S_PG_REG, S_PG_DAT,
        S_DEV, S_REG, S_DAT, S_NEXT, S_DELAY, S_DONE, S_ERR
    } state_t;

    typedef struct packed {
        logic [7:0] page;
        logic [7:0] regn;
        logic [7:0] data;
    } entry_t;

    state_t           state;
    entry_t           entry;
    logic [7:0]       cur_page;
    logic             page_valid;
    logic             issued;
    logic [TMO_W-1:0] tmo_cnt;
    logic [DLY_W-1:0] dly_cnt;

    logic             cmd_start_c;
    logic             cmd_stop_c;
    logic [7:0]       cmd_byte_c;
    state_t           cmd_next_c;

    logic             unused_dout;
    assign unused_dout = ^dout_i;

    assign read_o   = 1'b0;
    assign ack_in_o = 1'b0;

    // Byte, framing and successor for whichever command state is current
    always_comb begin
        cmd_start_c = 1'b0;
        cmd_stop_c  = 1'b0;
        cmd_byte_c  = 8'h00;
        cmd_next_c  = S_IDLE;
        case (state)
            S_PG_DEV: begin cmd_start_c = 1'b1; cmd_byte_c = ADDR_BYTE;  cmd_next_c = S_PG_REG; end
            S_PG_REG: begin                     cmd_byte_c = PAGE_REG;   cmd_next_c = S_PG_DAT; end
            S_PG_DAT: begin cmd_stop_c  = 1'b1; cmd_byte_c = entry.page; cmd_next_c = S_DEV;    end
            S_DEV:    begin cmd_start_c = 1'b1; cmd_byte_c = ADDR_BYTE;  cmd_next_c = S_REG;    end
            S_REG:    begin                     cmd_byte_c = entry.regn; cmd_next_c = S_DAT;    end
            S_DAT:    begin cmd_stop_c  = 1'b1; cmd_byte_c = entry.data; cmd_next_c = S_NEXT;   end
            default:  ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            entry      <= '0;
            cur_page   <= 8'h00;
            page_valid <= 1'b0;
            issued     <= 1'b0;
            tmo_cnt    <= '0;
            dly_cnt    <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            error_o    <= 1'b0;
            rom_addr_o <= '0;
            start_o    <= 1'b0;
            stop_o     <= 1'b0;
            write_o    <= 1'b0;
            din_o      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        done_o     <= 1'b0;
                        error_o    <= 1'b0;
                        busy_o     <= 1'b1;
                        rom_addr_o <= '0;
                        page_valid <= 1'b0;
                        state      <= S_FETCH;
                    end
                end
                S_FETCH: state <= S_LATCH;
                S_LATCH: begin
                    entry <= rom_data_i;
                    state <= (!page_valid || rom_data_i[23:16] != cur_page) ? S_PG_DEV : S_DEV;
                end
                // First cycle of a command state is left idle, guaranteeing a gap between commands
                S_PG_DEV, S_PG_REG, S_PG_DAT, S_DEV, S_REG, S_DAT: begin
                    if (!issued) begin
                        issued  <= 1'b1;
                        write_o <= 1'b1;
                        start_o <= cmd_start_c;
                        stop_o  <= cmd_stop_c;
                        din_o   <= DATA_WIDTH'(cmd_byte_c);
                        tmo_cnt <= '0;
                    end else if (cmd_ack_i || tmo_cnt == TMO_LAST) begin
                        issued  <= 1'b0;
                        write_o <= 1'b0;
                        start_o <= 1'b0;
                        stop_o  <= 1'b0;
                        din_o   <= '0;
                        if (cmd_ack_i) begin
                            state <= cmd_next_c;
                            if (state == S_PG_DAT) begin
                                cur_page   <= entry.page;
                                page_valid <= 1'b1;
                            end
                        end else begin
                            busy_o  <= 1'b0;
                            error_o <= 1'b1;
                            state   <= S_ERR;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                S_NEXT: begin
                    if (rom_addr_o == LAST_ADDR) begin
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        state  <= S_DONE;
                    end else if (PREAMBLE_LEN != 0 && rom_addr_o == PRE_ADDR) begin
                        dly_cnt <= '0;
                        state   <= S_DELAY;
                    end else begin
                        rom_addr_o <= rom_addr_o + AW'(1);
                        state      <= S_FETCH;
                    end
                end
                S_DELAY: begin
                    if (dly_cnt == DLY_LAST) begin
                        rom_addr_o <= rom_addr_o + AW'(1);
                        state      <= S_FETCH;
                    end else begin
                        dly_cnt <= dly_cnt + DLY_W'(1);
                    end
                end
                S_DONE, S_ERR: state <= S_IDLE;
                default:       state <= S_IDLE;
            endcase
        end
    end

endmodule
